// File: rtl/vme_pkg.sv
// rtl/vme_pkg.sv - shared constants, arbiter states and helpers for the slot-1 VME system controller
package vme_pkg;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    localparam int DEFAULT_GRANT_TIMEOUT = 64;
    localparam int DEFAULT_BERR_TIMEOUT  = 1024;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_BUSY,
        BUSY
    } arb_state_e;

    // Highest-index asserted request wins (PRI mode); later iterations override earlier ones.
    function automatic logic [1:0] highest_level(input logic [3:0] br_n);
        logic [1:0] lvl;
        lvl = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (br_n[i] == ACTIVE) begin
                lvl = 2'(i);
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/vme_system_controller_if.sv
// rtl/vme_system_controller_if.sv - VME arbitration and bus-timer signal bundle, all VME lines active-low
interface vme_system_controller_if;

    logic [3:0] vme_bus_request;
    logic [3:0] vme_bus_grant_out;
    logic       vme_bus_busy;
    logic       vme_as;
    logic [1:0] vme_ds;
    logic       vme_dtack;
    logic       vme_berr_in;
    logic       vme_berr_out;
    logic       grant_timeout;
    logic       berr_timeout;

    modport slave (
        input  vme_bus_request,
        input  vme_bus_busy,
        input  vme_as,
        input  vme_ds,
        input  vme_dtack,
        input  vme_berr_in,
        output vme_bus_grant_out,
        output vme_berr_out,
        output grant_timeout,
        output berr_timeout
    );

    modport master (
        output vme_bus_request,
        output vme_bus_busy,
        output vme_as,
        output vme_ds,
        output vme_dtack,
        output vme_berr_in,
        input  vme_bus_grant_out,
        input  vme_berr_out,
        input  grant_timeout,
        input  berr_timeout
    );

endinterface

// File: rtl/vme_bus_timer.sv
// rtl/vme_bus_timer.sv - VME bus timer: drives BERR when a data transfer stays unacknowledged too long
module vme_bus_timer #(
    parameter int BERR_TIMEOUT = vme_pkg::DEFAULT_BERR_TIMEOUT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       as_i,
    input  logic [1:0] ds_i,
    input  logic       dtack_i,
    input  logic       berr_i,
    output logic       berr_o,
    output logic       berr_timeout_o
);
    import vme_pkg::*;

    localparam int              CW    = $clog2(BERR_TIMEOUT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(BERR_TIMEOUT);
    localparam logic [CW-1:0]   LAST  = CW'(BERR_TIMEOUT - 1);

    logic [4:0]    sync1_q, sync2_q;
    logic          as_s, dtack_s, berr_s;
    logic [1:0]    ds_s;
    logic          ds_idle, armed, clear;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          berr_q, berr_d;
    logic          bto_q, bto_d;

    assign {as_s, ds_s, dtack_s, berr_s} = sync2_q;

    assign ds_idle = (ds_s == {INACTIVE, INACTIVE});
    assign armed   = (as_s == ACTIVE) && !ds_idle;
    assign clear   = (dtack_s == ACTIVE) || (berr_s == ACTIVE) || ds_idle;

    // The BERR drive is a separate flag so an observed BERR (our own, wired back) clears the
    // counter without dropping the drive before the master ends its cycle.
    always_comb begin
        cnt_d  = cnt_q;
        berr_d = berr_q;
        bto_d  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (armed && cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                berr_d = ACTIVE;
                bto_d  = 1'b1;
            end
        end
        if (ds_idle) begin
            berr_d = INACTIVE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            cnt_q   <= '0;
            berr_q  <= INACTIVE;
            bto_q   <= 1'b0;
        end else begin
            sync1_q <= {as_i, ds_i, dtack_i, berr_i};
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            berr_q  <= berr_d;
            bto_q   <= bto_d;
        end
    end

    assign berr_o         = berr_q;
    assign berr_timeout_o = bto_q;

endmodule

// File: rtl/vme_system_controller.sv
// rtl/vme_system_controller.sv - slot-1 VME system controller: PRI bus arbiter plus bus timer
module vme_system_controller #(
    parameter int GRANT_TIMEOUT = vme_pkg::DEFAULT_GRANT_TIMEOUT,
    parameter int BERR_TIMEOUT  = vme_pkg::DEFAULT_BERR_TIMEOUT
) (
    input  logic                     clock,
    input  logic                     reset,
    vme_system_controller_if.slave   bus
);
    import vme_pkg::*;

    localparam int            GW         = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [GW-1:0] GRANT_LAST = GW'(GRANT_TIMEOUT - 1);

    logic [3:0]    br_s1_q, br_s2_q;
    logic          bbsy_s1_q, bbsy_s2_q;
    logic          bbsy;
    arb_state_e    state_q, state_d;
    logic [1:0]    level_q, level_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [3:0]    grant_q, grant_d;
    logic          gto_q, gto_d;
    logic          berr_drive, berr_pulse;

    assign bbsy = (bbsy_s2_q == ACTIVE);

    // Priority inside WAIT_BUSY: BBSY, then request withdrawal, then expiry.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        gcnt_d  = gcnt_q;
        grant_d = {4{INACTIVE}};
        gto_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bbsy) begin
                    state_d = BUSY;
                end else if (br_s2_q != {4{INACTIVE}}) begin
                    level_d = highest_level(br_s2_q);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                grant_d[level_q] = ACTIVE;
                gcnt_d           = '0;
                state_d          = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bbsy) begin
                    state_d = BUSY;
                end else if (br_s2_q[level_q] == INACTIVE) begin
                    state_d = IDLE;
                end else if (gcnt_q == GRANT_LAST) begin
                    state_d = IDLE;
                    gto_d   = 1'b1;
                end else begin
                    gcnt_d           = gcnt_q + 1'b1;
                    grant_d[level_q] = ACTIVE;
                end
            end
            BUSY: begin
                if (!bbsy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            br_s1_q   <= {4{INACTIVE}};
            br_s2_q   <= {4{INACTIVE}};
            bbsy_s1_q <= INACTIVE;
            bbsy_s2_q <= INACTIVE;
            state_q   <= IDLE;
            level_q   <= 2'd0;
            gcnt_q    <= '0;
            grant_q   <= {4{INACTIVE}};
            gto_q     <= 1'b0;
        end else begin
            br_s1_q   <= bus.vme_bus_request;
            br_s2_q   <= br_s1_q;
            bbsy_s1_q <= bus.vme_bus_busy;
            bbsy_s2_q <= bbsy_s1_q;
            state_q   <= state_d;
            level_q   <= level_d;
            gcnt_q    <= gcnt_d;
            grant_q   <= grant_d;
            gto_q     <= gto_d;
        end
    end

    vme_bus_timer #(
        .BERR_TIMEOUT (BERR_TIMEOUT)
    ) u_bus_timer (
        .clock          (clock),
        .reset          (reset),
        .as_i           (bus.vme_as),
        .ds_i           (bus.vme_ds),
        .dtack_i        (bus.vme_dtack),
        .berr_i         (bus.vme_berr_in),
        .berr_o         (berr_drive),
        .berr_timeout_o (berr_pulse)
    );

    assign bus.vme_bus_grant_out = grant_q;
    assign bus.grant_timeout     = gto_q;
    assign bus.vme_berr_out      = berr_drive;
    assign bus.berr_timeout      = berr_pulse;

endmodule

// File: tb/tb_vme_system_controller.sv
// tb/tb_vme_system_controller.sv - event scoreboard bench for vme_system_controller
module tb_vme_system_controller;

    typedef struct {
        string      name;
        int         cyc;
        logic [6:0] vec;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   b;
    exp_t exp_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    vme_system_controller_if bus();

    vme_system_controller #(
        .GRANT_TIMEOUT (8),
        .BERR_TIMEOUT  (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Output vector layout: {grant_out[3:0], berr_out, grant_timeout, berr_timeout}
    task automatic expect_ev(input string nm, input int c, input logic [6:0] v);
        exp_t e;
        e.name = nm;
        e.cyc  = c;
        e.vec  = v;
        exp_q.push_back(e);
    endtask

    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin : monitor
        logic [6:0] prev;
        logic [6:0] cur;
        exp_t       e;
        prev = 7'bx;
        forever begin
            @(negedge clock);
            cur = {bus.vme_bus_grant_out, bus.vme_berr_out, bus.grant_timeout, bus.berr_timeout};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d got=%b required=no change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec !== cur) begin
                        errors++;
                        $display("FAIL %s got cyc=%0d out=%b required cyc=%0d out=%b",
                                 e.name, cyc, cur, e.cyc, e.vec);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        reset                   = 1'b1;
        bus.vme_bus_request     = 4'b1111;
        bus.vme_bus_busy        = 1'b1;
        bus.vme_as              = 1'b1;
        bus.vme_ds              = 2'b11;
        bus.vme_dtack           = 1'b1;
        bus.vme_berr_in         = 1'b1;
        expect_ev("reset_state", 1, 7'b1111_100);
        at(3);
        reset = 1'b0;

        // Single requester, BBSY five clocks after grant (coincides with expiry: BBSY wins)
        at(6);
        b = cyc;
        expect_ev("s1_grant",        b + 4,  7'b1101_100);
        expect_ev("s1_bbsy_release", b + 12, 7'b1111_100);
        expect_ev("s1_regrant",      b + 25, 7'b1101_100);
        expect_ev("s1_br_release",   b + 30, 7'b1111_100);
        bus.vme_bus_request = 4'b1101;
        at(b + 9);
        bus.vme_bus_busy = 1'b0;
        at(b + 20);
        bus.vme_bus_busy = 1'b1;
        at(b + 27);
        bus.vme_bus_request = 4'b1111;

        // Priority: BR3 and BR0 together
        at(b + 35);
        b = cyc;
        expect_ev("s2_grant_bg3",    b + 4,  7'b0111_100);
        expect_ev("s2_bg3_release",  b + 9,  7'b1111_100);
        expect_ev("s2_grant_bg0",    b + 17, 7'b1110_100);
        expect_ev("s2_bg0_release",  b + 21, 7'b1111_100);
        bus.vme_bus_request = 4'b0110;
        at(b + 6);
        bus.vme_bus_busy = 1'b0;
        at(b + 10);
        bus.vme_bus_request = 4'b1110;
        at(b + 12);
        bus.vme_bus_busy = 1'b1;
        at(b + 18);
        bus.vme_bus_busy = 1'b0;
        at(b + 22);
        bus.vme_bus_request = 4'b1111;
        at(b + 23);
        bus.vme_bus_busy = 1'b1;

        // Unclaimed grant, then withdrawal on the expiry cycle (no pulse)
        at(b + 30);
        b = cyc;
        expect_ev("s3_grant",        b + 4,  7'b1011_100);
        expect_ev("s3_timeout",      b + 12, 7'b1111_110);
        expect_ev("s3_pulse_end",    b + 13, 7'b1111_100);
        expect_ev("s3_regrant",      b + 14, 7'b1011_100);
        expect_ev("s3_withdraw_exp", b + 22, 7'b1111_100);
        bus.vme_bus_request = 4'b1011;
        at(b + 19);
        bus.vme_bus_request = 4'b1111;

        // Bus timer expiry and release
        at(b + 26);
        b = cyc;
        expect_ev("s4_berr",         b + 18, 7'b1111_001);
        expect_ev("s4_berr_pulse",   b + 19, 7'b1111_000);
        expect_ev("s4_berr_release", b + 28, 7'b1111_100);
        bus.vme_as = 1'b0;
        bus.vme_ds = 2'b10;
        at(b + 25);
        bus.vme_as = 1'b1;
        bus.vme_ds = 2'b11;

        // DTACK on the last clock before expiry: no BERR
        at(b + 32);
        b = cyc;
        bus.vme_as = 1'b0;
        bus.vme_ds = 2'b10;
        at(b + 15);
        bus.vme_dtack = 1'b0;
        at(b + 25);
        bus.vme_as    = 1'b1;
        bus.vme_ds    = 2'b11;
        bus.vme_dtack = 1'b1;

        // Reset while a grant and BERR are both active
        at(b + 32);
        b = cyc;
        expect_ev("s5_berr",         b + 18, 7'b1111_001);
        expect_ev("s5_berr_pulse",   b + 19, 7'b1111_000);
        expect_ev("s5_grant",        b + 20, 7'b0111_000);
        expect_ev("s5_reset",        b + 22, 7'b1111_100);
        expect_ev("s5_post_grant",   b + 29, 7'b1101_100);
        expect_ev("s5_post_release", b + 33, 7'b1111_100);
        bus.vme_as = 1'b0;
        bus.vme_ds = 2'b10;
        at(b + 16);
        bus.vme_bus_request = 4'b0111;
        at(b + 22);
        reset = 1'b1;
        at(b + 23);
        bus.vme_bus_request = 4'b1111;
        bus.vme_as          = 1'b1;
        bus.vme_ds          = 2'b11;
        at(b + 24);
        reset = 1'b0;
        at(b + 25);
        bus.vme_bus_request = 4'b1101;
        at(b + 30);
        bus.vme_bus_request = 4'b1111;

        at(b + 38);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d outstanding (next %s at cyc=%0d) required=0",
                     exp_q.size(), exp_q[0].name, exp_q[0].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
